// File: rtl/clock_alarm_if.sv
// Bus bundle for clock_alarm_ctrl: timer master port (tmr_*) and CPU slave port.
// slave = controller side, master = system/CPU side.
interface clock_alarm_if;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic        tmr_irq;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport slave (
    output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    input  tmr_irq,
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

  modport master (
    input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
    output tmr_irq,
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );
endinterface

// File: rtl/clock_alarm_ctrl.sv
// Interval-timer sequencer, HH:MM:SS time-of-day and alarm with CPU register map.
// Optional CLOCK_ALARM_BEEP_EN adds a beep output toggling per tick while the alarm is pending.
//
// state  | meaning
// S_INIT | write timer CONTROL (addr 1) = 1 to enable its IRQ
// S_IDLE | wait for timer IRQ
// S_CLR  | write timer STATUS (addr 0) = 0 to clear the timeout
// S_WAIT | let timer IRQ drop, IRQ ignored
// S_TICK | advance prescaler / time once
module clock_alarm_ctrl #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int PRE_W         = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  clock_alarm_if.slave bus
`ifdef CLOCK_ALARM_BEEP_EN
  ,
  output logic         beep_o
`endif
);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_CLR, S_WAIT, S_TICK} state_t;

  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  state_t      state_q;
  logic        tmr_cs_q, tmr_wr_n_q, init_done_q;
  logic [2:0]  tmr_addr_q;
  logic [15:0] tmr_data_q;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [5:0]  sec_q, sec_d, min_q, min_d, amin_q, amin_d;
  logic [4:0]  hr_q, hr_d, ahr_q, ahr_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        pend_q, pend_d, irq_q;
  logic [15:0] rdata_q;

  logic tick, adv, cpu_wr, cpu_rd;
  logic wr_sec, wr_min, wr_hr, wr_amin, wr_ahr, wr_ctrl, wr_stat_clr;
  logic pre_wrap, sec_carry, min_carry, alarm_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_INIT;
      tmr_cs_q    <= 1'b0;
      tmr_wr_n_q  <= 1'b1;
      tmr_addr_q  <= 3'd0;
      tmr_data_q  <= 16'd0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          tmr_cs_q    <= 1'b1;
          tmr_wr_n_q  <= 1'b0;
          tmr_addr_q  <= 3'd1;
          tmr_data_q  <= 16'd1;
          init_done_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        S_IDLE: begin
          tmr_addr_q <= 3'd0;
          tmr_data_q <= 16'd0;
          if (bus.tmr_irq) begin
            tmr_cs_q   <= 1'b1;
            tmr_wr_n_q <= 1'b0;
            state_q    <= S_CLR;
          end else begin
            tmr_cs_q   <= 1'b0;
            tmr_wr_n_q <= 1'b1;
          end
        end
        S_CLR: begin
          tmr_cs_q   <= 1'b0;
          tmr_wr_n_q <= 1'b1;
          state_q    <= S_WAIT;
        end
        S_WAIT:  state_q <= S_TICK;
        S_TICK:  state_q <= S_IDLE;
        default: state_q <= S_INIT;
      endcase
    end
  end

  assign tick   = (state_q == S_TICK);
  assign adv    = tick && ctrl_q[1];
  assign cpu_wr = bus.chipselect && !bus.write_n;
  assign cpu_rd = bus.chipselect && bus.write_n;

  assign wr_sec      = cpu_wr && (bus.address == 3'd0) && (bus.writedata < 16'd60);
  assign wr_min      = cpu_wr && (bus.address == 3'd1) && (bus.writedata < 16'd60);
  assign wr_hr       = cpu_wr && (bus.address == 3'd2) && (bus.writedata < 16'd24);
  assign wr_amin     = cpu_wr && (bus.address == 3'd3) && (bus.writedata < 16'd60);
  assign wr_ahr      = cpu_wr && (bus.address == 3'd4) && (bus.writedata < 16'd24);
  assign wr_ctrl     = cpu_wr && (bus.address == 3'd5);
  assign wr_stat_clr = cpu_wr && (bus.address == 3'd6) && bus.writedata[0];

  // A CPU-written field takes the write value and neither accepts nor propagates a carry.
  assign pre_wrap  = adv && (pre_q == PRE_MAX);
  assign sec_carry = pre_wrap && (sec_q == 6'd59) && !wr_sec;
  assign min_carry = sec_carry && (min_q == 6'd59) && !wr_min;

  always_comb begin
    pre_d = pre_q;
    if (adv) pre_d = pre_wrap ? '0 : pre_q + PRE_W'(1);
    if (wr_sec) pre_d = '0;

    sec_d = sec_q;
    if (pre_wrap) sec_d = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
    if (wr_sec) sec_d = bus.writedata[5:0];

    min_d = min_q;
    if (sec_carry) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    if (wr_min) min_d = bus.writedata[5:0];

    hr_d = hr_q;
    if (min_carry) hr_d = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
    if (wr_hr) hr_d = bus.writedata[4:0];

    amin_d = wr_amin ? bus.writedata[5:0] : amin_q;
    ahr_d  = wr_ahr  ? bus.writedata[4:0] : ahr_q;
    ctrl_d = wr_ctrl ? bus.writedata[1:0] : ctrl_q;
  end

  // Only a seconds carry can raise the alarm; CPU time writes never do.
  assign alarm_hit = sec_carry && ctrl_q[0] && (min_d == amin_q) && (hr_d == ahr_q);
  assign pend_d    = alarm_hit || (pend_q && !wr_stat_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q   <= '0;
      sec_q   <= 6'd0;
      min_q   <= 6'd0;
      hr_q    <= 5'd0;
      amin_q  <= 6'd0;
      ahr_q   <= 5'd0;
      ctrl_q  <= 2'b10;
      pend_q  <= 1'b0;
      irq_q   <= 1'b0;
      rdata_q <= 16'd0;
    end else begin
      pre_q  <= pre_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hr_q   <= hr_d;
      amin_q <= amin_d;
      ahr_q  <= ahr_d;
      ctrl_q <= ctrl_d;
      pend_q <= pend_d;
      irq_q  <= pend_d && ctrl_d[0];
      if (cpu_rd) begin
        case (bus.address)
          3'd0:    rdata_q <= {10'd0, sec_q};
          3'd1:    rdata_q <= {10'd0, min_q};
          3'd2:    rdata_q <= {11'd0, hr_q};
          3'd3:    rdata_q <= {10'd0, amin_q};
          3'd4:    rdata_q <= {11'd0, ahr_q};
          3'd5:    rdata_q <= {14'd0, ctrl_q};
          3'd6:    rdata_q <= {14'd0, init_done_q, pend_q};
          default: rdata_q <= 16'(pre_q);
        endcase
      end
    end
  end

`ifdef CLOCK_ALARM_BEEP_EN
  logic beep_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    beep_q <= 1'b0;
    else if (!pend_q) beep_q <= 1'b0;
    else if (tick)   beep_q <= ~beep_q;
  end

  assign beep_o = beep_q;
`endif

  assign bus.tmr_address    = tmr_addr_q;
  assign bus.tmr_chipselect = tmr_cs_q;
  assign bus.tmr_write_n    = tmr_wr_n_q;
  assign bus.tmr_writedata  = tmr_data_q;
  assign bus.readdata       = rdata_q;
  assign bus.irq            = irq_q;

endmodule
